// File: rtl/simd_seq_pkg.sv
// simd_seq_pkg: opcodes, state codes and instruction field layout shared by the SIMD sequencer
package simd_seq_pkg;
  localparam int DEF_N = 16;
  localparam int DEF_CNTW = 16;
  localparam int OPC_LSB = 0;
  localparam int IDX_LSB = 3;
  localparam int LEN_LSB = 16;
  localparam int KEEP_BIT = 15;
  typedef enum logic [2:0] {
    OP_NOP, OP_LDB, OP_LDA, OP_MAC, OP_STORE, OP_CLR, OP_ILL, OP_HALT
  } opcode_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MAC, S_HALTED} state_e;
  localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
  localparam logic [1:0] ST_EXEC = 2'(S_EXEC);
  localparam logic [1:0] ST_MAC  = 2'(S_MAC);
  localparam logic [1:0] ST_HALT = 2'(S_HALTED);
endpackage

// File: rtl/simd_onehot_dec.sv
// simd_onehot_dec: row index to MSB-first one-hot (idx 0 -> bit N-1)
module simd_onehot_dec import simd_seq_pkg::*; #(
  parameter int N = DEF_N,
  localparam int LogN = $clog2(N)
) (
  input  logic [LogN-1:0] idx_i,
  output logic [N-1:0]    onehot_o
);
  localparam logic [N-1:0] Top = {1'b1, {(N-1){1'b0}}};
  assign onehot_o = Top >> idx_i;
endmodule

// File: rtl/simd_seq_ctrl.sv
// simd_seq_ctrl: SIMD PE-array instruction sequencer; SIMD_SEQ_ACCUM_EN lets STORE keep=1 skip the multiplier reset
module simd_seq_ctrl import simd_seq_pkg::*; #(
  parameter int N = DEF_N,
  parameter int CNTW = DEF_CNTW,
  localparam int LogN = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic [31:0]     INSTR,
  input  logic            INSTR_VALID,
  output logic            INSTR_READY,
  input  logic            ONSWT,
  output logic            OFFSWT,
  output logic            ERR,
  output logic            DONE,
  output logic            MATAB_MUX,
  output logic            DOUT_MUX,
  output logic [LogN-1:0] SEQ_A,
  output logic [LogN-1:0] SEQ_B,
  output logic [LogN-1:0] SEQ_DATC,
  output logic [N-1:0]    MAC_CTRL,
  output logic [N-1:0]    RST_MUL,
  output logic [N-1:0]    INC_PC,
  output logic [N-1:0]    MAT_MUX,
  output logic [N-1:0]    WRITE_MAT
);
  logic [1:0] state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [LogN-1:0] addr_c_q, addr_c_d, seq_a_q, seq_a_d, seq_b_q, seq_b_d, seq_c_q, seq_c_d;
  logic err_q, err_d, off_q, off_d, done_q, done_d, mab_q, mab_d, dout_q, dout_d;
  logic [N-1:0] mac_q, mac_d, rst_q, rst_d, mmux_q, mmux_d, wr_q, wr_d;
  opcode_e opc;
  logic [LogN-1:0] idx;
  logic [15:0] len_f;
  logic [CNTW-1:0] len;
  logic [N-1:0] onehot;
  logic keep, hs;
  logic unused_bits;
  assign opc = opcode_e'(INSTR[OPC_LSB +: 3]);
  assign idx = INSTR[IDX_LSB +: LogN];
  assign len_f = INSTR[LEN_LSB +: 16];
  assign len = len_f == '0 ? CNTW'(N) : CNTW'(len_f);
  assign unused_bits = ^INSTR[KEEP_BIT:IDX_LSB+LogN];
`ifdef SIMD_SEQ_ACCUM_EN
  assign keep = INSTR[KEEP_BIT];
`else
  assign keep = 1'b0;
`endif
  assign INSTR_READY = state_q == ST_IDLE && ONSWT && !off_q;
  assign hs = INSTR_VALID && INSTR_READY;
  simd_onehot_dec #(.N(N)) u_dec (.idx_i(idx), .onehot_o(onehot));
  // Pulse-type controls default to 0 each cycle; row selects and sticky flags hold.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_c_d = addr_c_q;
    seq_a_d = seq_a_q;
    seq_b_d = seq_b_q;
    seq_c_d = seq_c_q;
    err_d = err_q;
    off_d = off_q;
    done_d = 1'b0;
    mab_d = 1'b0;
    dout_d = 1'b0;
    mac_d = '0;
    rst_d = '0;
    mmux_d = '0;
    wr_d = '0;
    case (state_q)
      ST_IDLE: if (hs) begin
        state_d = opc == OP_MAC ? ST_MAC : opc == OP_HALT ? ST_HALT : ST_EXEC;
        done_d = opc != OP_MAC || len == CNTW'(1);
        case (opc)
          OP_LDB: begin
            wr_d = onehot;
            seq_b_d = idx;
          end
          OP_LDA: begin
            wr_d = '1;
            mmux_d = '1;
            mab_d = 1'b1;
            seq_a_d = idx;
            addr_c_d = idx;
          end
          OP_MAC: begin
            mac_d = '1;
            cnt_d = len;
          end
          OP_STORE: begin
            dout_d = 1'b1;
            seq_c_d = addr_c_q;
            rst_d = keep ? '0 : '1;
          end
          OP_CLR: rst_d = '1;
          OP_ILL: err_d = 1'b1;
          OP_HALT: off_d = 1'b1;
          default: ;
        endcase
      end
      ST_EXEC: state_d = ST_IDLE;
      // cnt_q holds the number of MAC cycles left including the current one.
      ST_MAC: begin
        state_d = cnt_q == CNTW'(1) ? ST_IDLE : ST_MAC;
        cnt_d = cnt_q - CNTW'(1);
        mac_d = cnt_q == CNTW'(1) ? '0 : '1;
        done_d = cnt_q == CNTW'(2);
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      addr_c_q <= '0;
      seq_a_q <= '0;
      seq_b_q <= '0;
      seq_c_q <= '0;
      err_q <= 1'b0;
      off_q <= 1'b0;
      done_q <= 1'b0;
      mab_q <= 1'b0;
      dout_q <= 1'b0;
      mac_q <= '0;
      rst_q <= '1;
      mmux_q <= '0;
      wr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_c_q <= addr_c_d;
      seq_a_q <= seq_a_d;
      seq_b_q <= seq_b_d;
      seq_c_q <= seq_c_d;
      err_q <= err_d;
      off_q <= off_d;
      done_q <= done_d;
      mab_q <= mab_d;
      dout_q <= dout_d;
      mac_q <= mac_d;
      rst_q <= rst_d;
      mmux_q <= mmux_d;
      wr_q <= wr_d;
    end
  end
  assign OFFSWT = off_q;
  assign ERR = err_q;
  assign DONE = done_q;
  assign MATAB_MUX = mab_q;
  assign DOUT_MUX = dout_q;
  assign SEQ_A = seq_a_q;
  assign SEQ_B = seq_b_q;
  assign SEQ_DATC = seq_c_q;
  assign MAC_CTRL = mac_q;
  assign INC_PC = mac_q;
  assign RST_MUL = rst_q;
  assign MAT_MUX = mmux_q;
  assign WRITE_MAT = wr_q;
endmodule

// File: tb/tb_simd_seq_ctrl.sv
// tb_simd_seq_ctrl: directed test-plan sequences then random traffic against a cycle-timeline reference model
module tb_simd_seq_ctrl;
  localparam int N = 16;
  localparam int LogN = 4;
  logic CLK = 1'b0;
  logic RSTN, INSTR_VALID, ONSWT;
  logic [31:0] INSTR;
  logic INSTR_READY, OFFSWT, ERR, DONE, MATAB_MUX, DOUT_MUX;
  logic [LogN-1:0] SEQ_A, SEQ_B, SEQ_DATC;
  logic [N-1:0] MAC_CTRL, RST_MUL, INC_PC, MAT_MUX, WRITE_MAT;
  simd_seq_ctrl #(.N(N), .CNTW(16)) dut (
    .CLK(CLK), .RSTN(RSTN), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .ONSWT(ONSWT), .OFFSWT(OFFSWT), .ERR(ERR),
    .DONE(DONE), .MATAB_MUX(MATAB_MUX), .DOUT_MUX(DOUT_MUX), .SEQ_A(SEQ_A),
    .SEQ_B(SEQ_B), .SEQ_DATC(SEQ_DATC), .MAC_CTRL(MAC_CTRL), .RST_MUL(RST_MUL),
    .INC_PC(INC_PC), .MAT_MUX(MAT_MUX), .WRITE_MAT(WRITE_MAT)
  );
  always #5 CLK = ~CLK;
  int checks = 0;
  int errors = 0;
  // Reference model: expected outputs of the current cycle plus the cycle index at which the active op ends.
  bit known = 0;
  int cyc = 0;
  int op_end = 0;
  logic [N-1:0] e_wr, e_mmux, e_mac, e_rst;
  logic e_mab, e_dout, e_done, e_err, e_off;
  logic [LogN-1:0] e_sa, e_sb, e_sc, m_addrc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic bit m_ready();
    return known && cyc > op_end && !e_off && ONSWT;
  endfunction
  task automatic model_edge();
    int n, l;
    logic [2:0] op;
    logic [LogN-1:0] ix;
    bit acc;
    n = cyc + 1;
    acc = m_ready() && INSTR_VALID;
    if (!RSTN) begin
      known = 1;
      e_wr = '0; e_mmux = '0; e_mac = '0; e_rst = '1;
      e_mab = 0; e_dout = 0; e_done = 0; e_err = 0; e_off = 0;
      e_sa = '0; e_sb = '0; e_sc = '0; m_addrc = '0;
      op_end = n - 1;
    end else begin
      e_wr = '0; e_mmux = '0; e_mac = '0; e_rst = '0;
      e_mab = 0; e_dout = 0; e_done = 0;
      if (n <= op_end) begin
        e_mac = '1;
        e_done = n == op_end;
      end else if (acc) begin
        op = INSTR[2:0];
        ix = INSTR[3 +: LogN];
        l = INSTR[31:16] == 0 ? N : int'(INSTR[31:16]);
        op_end = cyc + (op == 3 ? l : 1);
        e_done = n == op_end;
        case (op)
          1: begin e_wr[N-1-ix] = 1'b1; e_sb = ix; end
          2: begin e_wr = '1; e_mmux = '1; e_mab = 1; e_sa = ix; m_addrc = ix; end
          3: e_mac = '1;
          4: begin
            e_dout = 1; e_sc = m_addrc; e_rst = '1;
`ifdef SIMD_SEQ_ACCUM_EN
            if (INSTR[15]) e_rst = '0;
`endif
          end
          5: e_rst = '1;
          6: e_err = 1;
          7: e_off = 1;
          default: ;
        endcase
      end
    end
    cyc = n;
  endtask
  task automatic check_outputs();
    chk("WRITE_MAT", WRITE_MAT, e_wr);
    chk("MAT_MUX", MAT_MUX, e_mmux);
    chk("MAC_CTRL", MAC_CTRL, e_mac);
    chk("INC_PC", INC_PC, e_mac);
    chk("RST_MUL", RST_MUL, e_rst);
    chk("MATAB_MUX", MATAB_MUX, e_mab);
    chk("DOUT_MUX", DOUT_MUX, e_dout);
    chk("DONE", DONE, e_done);
    chk("ERR", ERR, e_err);
    chk("OFFSWT", OFFSWT, e_off);
    chk("SEQ_A", SEQ_A, e_sa);
    chk("SEQ_B", SEQ_B, e_sb);
    chk("SEQ_DATC", SEQ_DATC, e_sc);
  endtask
  task automatic step(input logic r, input logic on, input logic v, input logic [31:0] ins);
    RSTN = r; ONSWT = on; INSTR_VALID = v; INSTR = ins;
    #1;
    if (known) chk("INSTR_READY", INSTR_READY, m_ready());
    model_edge();
    @(posedge CLK);
    #1;
    check_outputs();
  endtask
  function automatic logic [31:0] mk(input int op, input int ix, input int ln);
    return {16'(ln), 13'(ix), 3'(op)};
  endfunction
  initial begin
    int cnt;
    logic [31:0] ins;
    logic [15:0] ln;
    RSTN = 0; ONSWT = 1; INSTR_VALID = 0; INSTR = '0;
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("reset_rst_mul", RST_MUL, 32'hFFFF);
    chk("reset_mac", MAC_CTRL, 0);
    chk("ready_after_reset", INSTR_READY, 1);
    step(1, 1, 1, mk(1, 5, 0));
    chk("ldb_write_mat", WRITE_MAT, 32'h0400);
    chk("ldb_seq_b", SEQ_B, 5);
    chk("ldb_done", DONE, 1);
    step(1, 1, 0, 0);
    chk("ldb_write_clear", WRITE_MAT, 0);
    step(1, 1, 1, mk(2, 9, 0));
    chk("lda_seq_a", SEQ_A, 9);
    step(1, 1, 0, 0);
    step(1, 1, 1, mk(4, 2, 0));
    chk("store_seq_datc", SEQ_DATC, 9);
    chk("store_dout", DOUT_MUX, 1);
    chk("store_rst_mul", RST_MUL, 32'hFFFF);
    step(1, 1, 0, 0);
    step(1, 1, 1, mk(3, 0, 0));
    cnt = int'(MAC_CTRL == '1);
    repeat (20) begin step(1, 1, 0, 0); cnt += int'(MAC_CTRL == '1); end
    chk("mac_len0_cycles", cnt, 16);
    step(1, 1, 1, mk(3, 0, 3));
    cnt = int'(MAC_CTRL == '1);
    repeat (6) begin step(1, 1, 0, 0); cnt += int'(MAC_CTRL == '1); end
    chk("mac_len3_cycles", cnt, 3);
    step(1, 1, 1, mk(3, 0, 8));
    cnt = int'(MAC_CTRL == '1);
    repeat (12) begin step(1, 0, 1, mk(0, 0, 0)); cnt += int'(MAC_CTRL == '1); end
    chk("mac_onswt_cycles", cnt, 8);
    chk("ready_onswt_low", INSTR_READY, 0);
    step(1, 1, 1, mk(6, 0, 0));
    chk("ill_err", ERR, 1);
    chk("ill_done", DONE, 1);
    step(1, 1, 0, 0);
    step(1, 1, 1, mk(0, 0, 0));
    chk("nop_done", DONE, 1);
    chk("err_sticky", ERR, 1);
    step(1, 1, 0, 0);
    step(1, 1, 1, mk(3, 0, 0));
    repeat (3) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("rst_mid_mac_mac", MAC_CTRL, 0);
    chk("rst_mid_mac_rst", RST_MUL, 32'hFFFF);
    step(1, 1, 1, mk(4, 0, 0) | 32'h8000);
`ifdef SIMD_SEQ_ACCUM_EN
    chk("store_keep_rst", RST_MUL, 0);
`else
    chk("store_keep_rst", RST_MUL, 32'hFFFF);
`endif
    step(1, 1, 0, 0);
    step(1, 1, 1, mk(7, 0, 0));
    chk("halt_off", OFFSWT, 1);
    repeat (4) step(1, 1, 1, mk(1, 3, 0));
    chk("halt_ready", INSTR_READY, 0);
    for (int i = 0; i < 3000; i++) begin
      ln = $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom_range(1, 6));
      ins = {ln, 16'($urandom)};
      ins[2:0] = $urandom_range(0, 15) == 0 ? 3'd7 : 3'($urandom_range(0, 6));
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, ins);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
